// File: rtl/scalar_mul_pkg.sv
// Shared types and constants for the scalar-multiplication command sequencer.
package scalar_mul_pkg;

    localparam int unsigned DATA = 256;
    localparam int unsigned ADDR = 6;
    localparam int unsigned IDXW = $clog2(DATA);

    localparam logic [ADDR-1:0] DEF_K_ADDR = 6'd2;
    localparam logic [ADDR-1:0] DEF_P_ADDR = 6'd3;
    localparam logic [ADDR-1:0] DEF_Q_ADDR = 6'd5;

    localparam int unsigned ST_BUSY   = 0;
    localparam int unsigned ST_DONE   = 1;
    localparam int unsigned ST_ERR    = 2;
    localparam int unsigned ST_IDX_LO = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_K,
        S_RD_PX,
        S_RD_PY,
        S_SCAN,
        S_INIT,
        S_DBL,
        S_ADD,
        S_WR_QX,
        S_WR_QY,
        S_DONE
    } state_e;

    typedef enum logic {
        PU_DBL = 1'b0,
        PU_ADD = 1'b1
    } pu_op_e;

endpackage

// File: rtl/scalar_mul_ctrl_if.sv
// Port-B RAM, command/status and point-unit handshake bundle for the sequencer.
interface scalar_mul_ctrl_if;
    import scalar_mul_pkg::*;

    logic [DATA-1:0] command;
    logic [DATA-1:0] status;
    logic            b_w;
    logic [ADDR-1:0] b_adbus;
    logic [DATA-1:0] b_data_in;
    logic [DATA-1:0] b_data_out;
    logic            pu_req;
    logic            pu_op;
    logic            pu_init;
    logic [DATA-1:0] pu_px;
    logic [DATA-1:0] pu_py;
    logic            pu_ack;
    logic [DATA-1:0] pu_rx;
    logic [DATA-1:0] pu_ry;

    modport master (
        input  command, b_data_out, pu_ack, pu_rx, pu_ry,
        output status, b_w, b_adbus, b_data_in, pu_req, pu_op, pu_init, pu_px, pu_py
    );

    modport slave (
        output command, b_data_out, pu_ack, pu_rx, pu_ry,
        input  status, b_w, b_adbus, b_data_in, pu_req, pu_op, pu_init, pu_px, pu_py
    );

endinterface

// File: rtl/scalar_mul_bitscan.sv
// Scalar shift register with remaining-bit counter; the current bit is always the MSB.
module scalar_mul_bitscan
    import scalar_mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic [DATA-1:0] k_in,
    input  logic            shift,
    output logic            msb,
    output logic            zero,
    output logic            last,
    output logic [IDXW-1:0] idx
);

    logic [DATA-1:0] k_q, k_d;
    logic [IDXW-1:0] idx_q, idx_d;

    always_comb begin
        k_d   = k_q;
        idx_d = idx_q;
        if (clear) begin
            k_d   = '0;
            idx_d = '0;
        end else if (load) begin
            k_d   = k_in;
            idx_d = IDXW'(DATA - 1);
        end else if (shift) begin
            k_d   = {k_q[DATA-2:0], 1'b0};
            idx_d = idx_q - IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            idx_q <= '0;
        end else begin
            k_q   <= k_d;
            idx_q <= idx_d;
        end
    end

    assign msb  = k_q[DATA-1];
    assign zero = (k_q == '0);
    assign last = (idx_q == '0);
    assign idx  = idx_q;

endmodule

// File: rtl/scalar_mul_ctrl.sv
// Command sequencer: fetches k and P over RAM port B, runs MSB-first double-and-add
// through the point unit, and writes Q = k*P back.
module scalar_mul_ctrl
    import scalar_mul_pkg::*;
#(
    parameter logic [ADDR-1:0] K_ADDR = DEF_K_ADDR,
    parameter logic [ADDR-1:0] P_ADDR = DEF_P_ADDR,
    parameter logic [ADDR-1:0] Q_ADDR = DEF_Q_ADDR
) (
    input logic               clk,
    input logic               rst,
    scalar_mul_ctrl_if.master bus
);

    state_e          state_q, state_d;
    logic            go_q, go_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            b_w_q, b_w_d;
    logic [ADDR-1:0] b_adbus_q, b_adbus_d;
    logic [DATA-1:0] b_data_in_q, b_data_in_d;
    logic            pu_req_q, pu_req_d, pu_init_q, pu_init_d;
    pu_op_e          pu_op_q, pu_op_d;
    logic [DATA-1:0] px_q, px_d, py_q, py_d, ry_q, ry_d;
    logic            py_pend_q, py_pend_d;

    logic            bs_clear, bs_load, bs_shift, bs_msb, bs_zero, bs_last;
    logic [IDXW-1:0] bs_idx;
    logic [DATA-1:0] status_w;

    scalar_mul_bitscan u_bitscan (
        .clk   (clk),
        .rst   (rst),
        .clear (bs_clear),
        .load  (bs_load),
        .k_in  (bus.b_data_out),
        .shift (bs_shift),
        .msb   (bs_msb),
        .zero  (bs_zero),
        .last  (bs_last),
        .idx   (bs_idx)
    );

    always_comb begin
        state_d     = state_q;
        go_d        = bus.command[0];
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        b_w_d       = b_w_q;
        b_adbus_d   = b_adbus_q;
        b_data_in_d = b_data_in_q;
        pu_req_d    = pu_req_q;
        pu_init_d   = pu_init_q;
        pu_op_d     = pu_op_q;
        px_d        = px_q;
        py_d        = py_q;
        ry_d        = ry_q;
        py_pend_d   = py_pend_q;
        bs_clear    = 1'b0;
        bs_load     = 1'b0;
        bs_shift    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.command[0] && !go_q) begin
                    state_d   = S_RD_K;
                    b_adbus_d = K_ADDR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_RD_K: begin
                state_d   = S_RD_PX;
                b_adbus_d = P_ADDR;
            end
            // Read data trails the address by one cycle, so each capture lags its issue state.
            S_RD_PX: begin
                state_d   = S_RD_PY;
                b_adbus_d = P_ADDR + ADDR'(1);
                bs_load   = 1'b1;
            end
            S_RD_PY: begin
                state_d   = S_SCAN;
                px_d      = bus.b_data_out;
                py_pend_d = 1'b1;
            end
            S_SCAN: begin
                py_pend_d = 1'b0;
                if (py_pend_q) py_d = bus.b_data_out;
                if (bs_zero) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    bs_clear = 1'b1;
                end else if (bs_msb) begin
                    state_d = S_INIT;
                end else begin
                    bs_shift = 1'b1;
                end
            end
            S_INIT, S_DBL, S_ADD: begin
                if (!pu_req_q) begin
                    pu_req_d  = 1'b1;
                    pu_init_d = (state_q == S_INIT);
                    pu_op_d   = (state_q == S_ADD) ? PU_ADD : PU_DBL;
                end else if (bus.pu_ack) begin
                    pu_req_d  = 1'b0;
                    pu_init_d = 1'b0;
                    if (state_q == S_DBL && bs_msb) begin
                        state_d = S_ADD;
                    end else if (bs_last) begin
                        state_d     = S_WR_QX;
                        b_w_d       = 1'b1;
                        b_adbus_d   = Q_ADDR;
                        b_data_in_d = bus.pu_rx;
                        ry_d        = bus.pu_ry;
                    end else begin
                        bs_shift = 1'b1;
                        state_d  = S_DBL;
                    end
                end
            end
            S_WR_QX: begin
                state_d     = S_WR_QY;
                b_adbus_d   = Q_ADDR + ADDR'(1);
                b_data_in_d = ry_q;
            end
            S_WR_QY: begin
                state_d = S_DONE;
                b_w_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            b_w_q       <= 1'b0;
            b_adbus_q   <= '0;
            b_data_in_q <= '0;
            pu_req_q    <= 1'b0;
            pu_init_q   <= 1'b0;
            pu_op_q     <= PU_DBL;
            px_q        <= '0;
            py_q        <= '0;
            ry_q        <= '0;
            py_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            b_w_q       <= b_w_d;
            b_adbus_q   <= b_adbus_d;
            b_data_in_q <= b_data_in_d;
            pu_req_q    <= pu_req_d;
            pu_init_q   <= pu_init_d;
            pu_op_q     <= pu_op_d;
            px_q        <= px_d;
            py_q        <= py_d;
            ry_q        <= ry_d;
            py_pend_q   <= py_pend_d;
        end
    end

    always_comb begin
        status_w                      = '0;
        status_w[ST_BUSY]             = busy_q;
        status_w[ST_DONE]             = done_q;
        status_w[ST_ERR]              = err_q;
        status_w[ST_IDX_LO +: IDXW]   = bs_idx;
    end

    assign bus.status    = status_w;
    assign bus.b_w       = b_w_q;
    assign bus.b_adbus   = b_adbus_q;
    assign bus.b_data_in = b_data_in_q;
    assign bus.pu_req    = pu_req_q;
    assign bus.pu_op     = pu_op_q;
    assign bus.pu_init   = pu_init_q;
    assign bus.pu_px     = px_q;
    assign bus.pu_py     = py_q;

endmodule
